// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with dual write, write bypass and a hardware clear sweep
// A sweep zeroes every entry after reset or on clr_req. Port 1 wins a same-address dual write.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we0,
   input  logic [ADDR_W-1:0]          waddr0,
   input  logic [DATA_W-1:0]          wdata0,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          waddr1,
   input  logic [DATA_W-1:0]          wdata1,
   input  logic                       clr_req,
   input  logic [NUM_RD-1:0]          re,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   output logic                       busy,
   output logic                       wcol
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   ptr, ptr_n;
   logic [DATA_W-1:0]   regs [DEPTH];
   logic                wr0, wr1;

   assign busy = (state == CLEAR);

   // Writes are only accepted outside the sweep and outside reset
   assign wr0 = !rst && (state == IDLE) && we0 && ((ZERO_REG == 0) || (waddr0 != '0));
   assign wr1 = !rst && (state == IDLE) && we1 && ((ZERO_REG == 0) || (waddr1 != '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_n = CLEAR;
               ptr_n   = '0;
            end
         end
         CLEAR: begin
            ptr_n = ptr + 1'b1;
            if (ptr == {ADDR_W{1'b1}}) begin
               state_n = IDLE;
               ptr_n   = '0;
            end
         end
         default: state_n = CLEAR;
      endcase
   end

   // Port 1 is written last so it overrides port 0 on an address match
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            regs[ptr] <= '0;
         end else begin
            if (wr0) regs[waddr0] <= wdata0;
            if (wr1) regs[waddr1] <= wdata1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) wcol <= 1'b0;
      else     wcol <= wr0 && wr1 && (waddr0 == waddr1);
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = raddr[g*ADDR_W +: ADDR_W];

      // Bypass compares raw enables: same-cycle writeback is visible before it lands
      always_comb begin
         rd = '0;
         if (rst || busy || !re[g])            rd = '0;
         else if ((ZERO_REG != 0) && ra == '0) rd = '0;
         else if (we1 && waddr1 == ra)         rd = wdata1;
         else if (we0 && waddr0 == ra)         rd = wdata0;
         else                                  rd = regs[ra];
      end

      assign rdata[g*DATA_W +: DATA_W] = rd;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp
// Table vectors for steady-state behaviour, hand sequences for reset and clear sweeps.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        we0, we1, clr_req;
   logic [4:0]  waddr0, waddr1, raddr0, raddr1;
   logic [31:0] wdata0, wdata1;
   logic [1:0]  re;
   logic [63:0] rdata;
   logic        busy, wcol;

   int nchk = 0;
   int nfail = 0;
   int n;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .rst(rst),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .clr_req(clr_req), .re(re), .raddr({raddr1, raddr0}),
      .rdata(rdata), .busy(busy), .wcol(wcol)
   );

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [1:0]  re;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic        exp_wcol;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_in();
      we0 = 0; waddr0 = 0; wdata0 = 0;
      we1 = 0; waddr1 = 0; wdata1 = 0;
      clr_req = 0; re = 0; raddr0 = 0; raddr1 = 0;
   endtask

   // Entered at a drive point (just after an edge); returns at a drive point.
   task automatic busy_run(input int wr_at, input int stop_at, output int cnt);
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         if (!busy) break;
         cnt++;
         clear_in();
         re = 2'b01; raddr0 = 5'd4;
         if (cnt == wr_at) begin
            we0 = 1; waddr0 = 5'd4; wdata0 = 32'h99;
         end
         @(negedge clk);
         if (cnt == wr_at) chk("rd_while_busy", rdata[31:0], 32'h0);
         @(posedge clk); #1;
         if (cnt == stop_at) break;
      end
   endtask

   initial begin
      vt[0]  = '{1, 5'd3, 32'hAAAA0003, 1, 5'd7, 32'h55550007, 2'b11, 5'd3, 5'd7, 32'hAAAA0003, 32'h55550007, 0};
      vt[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd3, 5'd7, 32'hAAAA0003, 32'h55550007, 0};
      vt[2]  = '{1, 5'd5, 32'h11111111, 1, 5'd5, 32'h22222222, 2'b11, 5'd5, 5'd5, 32'h22222222, 32'h22222222, 0};
      vt[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd5, 5'd5, 32'h22222222, 32'h22222222, 1};
      vt[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b01, 5'd5, 5'd7, 32'h22222222, 32'h0,        0};
      vt[5]  = '{1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 32'h0,        32'h0,        0};
      vt[6]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd0, 5'd5, 32'h0,        32'h22222222, 0};
      vt[7]  = '{1, 5'd9, 32'h9,        0, 5'd9, 32'hDEADBEEF, 2'b11, 5'd9, 5'd9, 32'h9,        32'h9,        0};
      vt[8]  = '{1, 5'd9, 32'h9,        1, 5'd9, 32'hA,        2'b11, 5'd9, 5'd9, 32'hA,        32'hA,        0};
      vt[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd9, 5'd3, 32'hA,        32'hAAAA0003, 1};
      vt[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b10, 5'd3, 5'd7, 32'h0,        32'h55550007, 0};
      vt[11] = '{1, 5'd7, 32'h77777777, 1, 5'd3, 32'h33333333, 2'b11, 5'd7, 5'd3, 32'h77777777, 32'h33333333, 0};
      vt[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd3, 5'd7, 32'h33333333, 32'h77777777, 0};

      // Reset: rdata forced to zero even with an active bypass
      clear_in();
      rst = 1;
      we1 = 1; waddr1 = 5'd3; wdata1 = 32'h12345678; re = 2'b11; raddr0 = 5'd3; raddr1 = 5'd3;
      @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'h1);
      chk("rst_wcol", {31'b0, wcol}, 32'h0);
      chk("rst_rdata0", rdata[31:0], 32'h0);
      chk("rst_rdata1", rdata[63:32], 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 0;
      clear_in();
      busy_run(0, 0, n);
      chk("init_clear_cycles", n, 32'd32);

      for (int a = 0; a < 32; a++) begin
         re = 2'b11; raddr0 = a[4:0]; raddr1 = a[4:0];
         @(negedge clk);
         chk("cleared_entry", rdata[31:0], 32'h0);
         @(posedge clk); #1;
      end

      for (int i = 0; i < 13; i++) begin
         we0 = vt[i].we0; waddr0 = vt[i].wa0; wdata0 = vt[i].wd0;
         we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
         clr_req = 0; re = vt[i].re; raddr0 = vt[i].ra0; raddr1 = vt[i].ra1;
         @(negedge clk);
         chk($sformatf("vec%0d_rdata0", i), rdata[31:0], vt[i].exp0);
         chk($sformatf("vec%0d_rdata1", i), rdata[63:32], vt[i].exp1);
         chk($sformatf("vec%0d_wcol", i), {31'b0, wcol}, {31'b0, vt[i].exp_wcol});
         chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'h0);
         @(posedge clk); #1;
      end

      // clr_req sweep: same-cycle write lands then gets wiped; mid-sweep write is dropped
      clear_in();
      we0 = 1; waddr0 = 5'd4; wdata0 = 32'h44;
      @(negedge clk);
      @(posedge clk); #1;
      clear_in();
      re = 2'b01; raddr0 = 5'd4; clr_req = 1;
      we1 = 1; waddr1 = 5'd6; wdata1 = 32'h66;
      @(negedge clk);
      chk("pre_clr_r4", rdata[31:0], 32'h44);
      chk("pre_clr_busy", {31'b0, busy}, 32'h0);
      @(posedge clk); #1;
      clear_in();
      chk("clr_req_busy", {31'b0, busy}, 32'h1);
      busy_run(10, 0, n);
      chk("clr_req_cycles", n, 32'd32);
      re = 2'b11; raddr0 = 5'd4; raddr1 = 5'd6;
      @(negedge clk);
      chk("post_clr_r4", rdata[31:0], 32'h0);
      chk("post_clr_r6", rdata[63:32], 32'h0);
      @(posedge clk); #1;

      // rst at busy cycle 20 restarts the sweep from zero
      clear_in();
      clr_req = 1;
      @(negedge clk);
      @(posedge clk); #1;
      clear_in();
      busy_run(0, 19, n);
      chk("pre_rst_cycles", n, 32'd19);
      rst = 1;
      re = 2'b01; raddr0 = 5'd9;
      @(negedge clk);
      chk("mid_rst_busy", {31'b0, busy}, 32'h1);
      chk("mid_rst_rdata", rdata[31:0], 32'h0);
      @(posedge clk); #1;
      rst = 0;
      clear_in();
      busy_run(0, 0, n);
      chk("restart_cycles", n, 32'd32);
      re = 2'b01; raddr0 = 5'd9;
      @(negedge clk);
      chk("post_restart_r9", rdata[31:0], 32'h0);
      chk("post_restart_wcol", {31'b0, wcol}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
